memory_32_5_arb: RTL
====================

# memory_32_5_arb

Two-requester arbiter and sequencer for a 32-word x 32-bit single-write/single-read synchronous memory (5-bit address, 2-cycle registered read path). Accepts read and write requests from requester A and requester B, grants one per cycle by round-robin, drives the memory's write and read ports, and tracks in-flight reads so each read response returns to the requester that issued it. Sits between the two datapath clients and the memory instance.

## Interface
Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 32, memory data width
- RD_LAT, 2, memory read latency in cycles from `mem_rd_address` to `mem_rd_data`; fixed at 2

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_req_vld  in  1  requester A request valid
- a_req_wr  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_W  request address
- a_req_wdata  in  DATA_W  write data
- a_req_rdy  out  1  A request accepted this cycle
- a_rsp_vld  out  1  A read data valid
- a_rsp_data  out  DATA_W  A read data
- b_req_vld, b_req_wr, b_req_addr, b_req_wdata, b_req_rdy, b_rsp_vld, b_rsp_data  same as A, for requester B
- mem_wr_vld  out  1  memory write enable
- mem_wr_address  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_address  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory read data

## Operation
- One request is granted per cycle; a transfer occurs when `x_req_vld && x_req_rdy`.
- `x_req_rdy` is combinational from the `vld` inputs and the priority pointer; `rdy` is never asserted without the matching `vld`.
- Round-robin state `last_b` (1 bit, reset 0):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if `last_b == 1`, else grant B.
  - `last_b` updates only on a grant: 1 after a B grant, 0 after an A grant.
  - After reset, the first contested cycle grants B, then alternates.
- Granted write:
  - `mem_wr_vld = 1`.
  - `mem_wr_address` and `mem_wr_data` are taken from the winner.
  - No response is generated.
- Granted read:
  - `mem_rd_address` is the winner's address.
  - The issue pipeline records (valid=1, owner).
- When no read is granted, `mem_rd_address = 0` and the pipeline entry is invalid.
- When no write is granted, `mem_wr_vld = 0` and write address/data = 0.
- Response pipeline:
  - 2-stage shift register of {valid, owner}, reset to all invalid.
  - Stage 2 selects the destination. `a_rsp_vld = s2.valid && owner==A`; same for B.
  - `x_rsp_data = mem_rd_data` when the matching `rsp_vld` is high, else 0.
- Ordering:
  - Read-after-write to the same address, granted in consecutive cycles, returns the new data.
  - A read and a write never issue in the same cycle (single grant per cycle).
- Reset mid-operation: pipeline entries are cleared, in-flight reads are dropped, and no `rsp_vld` is raised in the following cycles.

## Timing
- Read grant in cycle N gives `x_rsp_vld` in cycle N+2. Sustained back-to-back reads give one response per cycle.
- Write grant in cycle N commits at the clock edge ending cycle N.
- Reset values: all `rsp_vld` = 0, `rsp_data` = 0, `mem_wr_vld` = 0. Because `rdy` is combinational, `rdy` follows the inputs during reset; requests accepted while reset is high are ignored, with no write and no response.
- No combinational path from `mem_rd_data` to any `rdy`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - A always wins when both requesters are valid.
  - `last_b` is not implemented.
  - B is granted only when A is not valid.
- `MEM_ARB_FIXED_PRIO_EN` undefined: round-robin as described in Operation.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 3, then A reads addr 3 → `a_req_rdy` = 1 both cycles; `a_rsp_vld` = 1 exactly 2 cycles after the read grant with `a_rsp_data` = 0xDEADBEEF; `b_rsp_vld` stays 0.
- A and B both continuously request reads (A addr 1, B addr 2, preloaded 0x11 and 0x22) for 6 cycles → grants B, A, B, A, B, A; responses alternate 0x22 to B and 0x11 to A, each 2 cycles after its grant. With `MEM_ARB_FIXED_PRIO_EN`: A granted all 6 cycles and B never.
- B writes 0x55 to addr 31, then A reads addr 31 in the next cycle → A receives 0x55 (read-after-write).
- Reads issued back-to-back to addrs 0..31 by B after a fill with data = addr → 32 consecutive `b_rsp_vld` cycles with data 0..31 in order.
- A read granted in cycle N, then `reset` asserted in cycle N+1 → no `a_rsp_vld` in N+2 or N+3; after reset, the first contested grant goes to B.
- Both `vld` inputs low → `mem_wr_vld` = 0, both `rdy` = 0, `last_b` unchanged (verify with a following contested cycle).

Source files
------------

// File: rtl/memory_32_5_arb_if.sv
// Bus bundle between two requesters, the arbiter and a 32x32 memory.
// slave: arbiter side; master: requester/memory side.
interface memory_32_5_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_req_vld;
    logic              a_req_wr;
    logic [ADDR_W-1:0] a_req_addr;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_req_rdy;
    logic              a_rsp_vld;
    logic [DATA_W-1:0] a_rsp_data;

    logic              b_req_vld;
    logic              b_req_wr;
    logic [ADDR_W-1:0] b_req_addr;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_req_rdy;
    logic              b_rsp_vld;
    logic [DATA_W-1:0] b_rsp_data;

    logic              mem_wr_vld;
    logic [ADDR_W-1:0] mem_wr_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic [ADDR_W-1:0] mem_rd_address;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  a_req_vld, a_req_wr, a_req_addr, a_req_wdata,
        output a_req_rdy, a_rsp_vld, a_rsp_data,
        input  b_req_vld, b_req_wr, b_req_addr, b_req_wdata,
        output b_req_rdy, b_rsp_vld, b_rsp_data,
        output mem_wr_vld, mem_wr_address, mem_wr_data,
        output mem_rd_address,
        input  mem_rd_data
    );

    modport master (
        output a_req_vld, a_req_wr, a_req_addr, a_req_wdata,
        input  a_req_rdy, a_rsp_vld, a_rsp_data,
        output b_req_vld, b_req_wr, b_req_addr, b_req_wdata,
        input  b_req_rdy, b_rsp_vld, b_rsp_data,
        input  mem_wr_vld, mem_wr_address, mem_wr_data,
        input  mem_rd_address,
        output mem_rd_data
    );
endinterface

// File: rtl/memory_32_5_arb.sv
// Two-requester arbiter/sequencer for a 32x32 memory, 2-cycle read.
// Ports: clk, reset (sync, active-high), bus (memory_32_5_arb_if.slave).
// Build option: MEM_ARB_FIXED_PRIO_EN gives A fixed priority over B;
// without it, contested cycles alternate by round-robin (B first).
module memory_32_5_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    memory_32_5_arb_if.slave    bus
);
    logic              gnt_a;
    logic              gnt_b;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              wr_issue;
    logic              rd_issue;

    // Response pipeline: valid and owner (1 = B) per read stage
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] own_q, own_d;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_a = bus.a_req_vld;
        gnt_b = bus.b_req_vld && !bus.a_req_vld;
    end
`else
    logic last_b_q, last_b_d;

    always_ff @(posedge clk) begin
        if (reset) last_b_q <= 1'b0;
        else       last_b_q <= last_b_d;
    end

    always_comb begin
        last_b_d = last_b_q;
        if (gnt_a)      last_b_d = 1'b0;
        else if (gnt_b) last_b_d = 1'b1;
    end

    // Contested: whoever did not win last time
    always_comb begin
        gnt_a = bus.a_req_vld && (!bus.b_req_vld || last_b_q);
        gnt_b = bus.b_req_vld && (!bus.a_req_vld || !last_b_q);
    end
`endif

    always_comb begin
        bus.a_req_rdy = gnt_a;
        bus.b_req_rdy = gnt_b;
    end

    always_comb begin
        win_wr   = 1'b0;
        win_addr = '0;
        win_data = '0;
        if (gnt_a) begin
            win_wr   = bus.a_req_wr;
            win_addr = bus.a_req_addr;
            win_data = bus.a_req_wdata;
        end else if (gnt_b) begin
            win_wr   = bus.b_req_wr;
            win_addr = bus.b_req_addr;
            win_data = bus.b_req_wdata;
        end
    end

    // Handshakes during reset are dropped: no write, no read issue
    always_comb begin
        wr_issue = (gnt_a || gnt_b) && win_wr && !reset;
        rd_issue = (gnt_a || gnt_b) && !win_wr && !reset;
    end

    always_comb begin
        bus.mem_wr_vld     = wr_issue;
        bus.mem_wr_address = wr_issue ? win_addr : '0;
        bus.mem_wr_data    = wr_issue ? win_data : '0;
        bus.mem_rd_address = rd_issue ? win_addr : '0;
    end

    always_comb begin
        vld_d = {vld_q[RD_LAT-2:0], rd_issue};
        own_d = {own_q[RD_LAT-2:0], gnt_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    always_comb begin
        bus.a_rsp_vld  = vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
        bus.b_rsp_vld  = vld_q[RD_LAT-1] && own_q[RD_LAT-1];
        bus.a_rsp_data = bus.a_rsp_vld ? bus.mem_rd_data : '0;
        bus.b_rsp_data = bus.b_rsp_vld ? bus.mem_rd_data : '0;
    end
endmodule
